operand_loader: RTL and testbench
=================================

# operand_loader

Upstream input stage of the ALU datapath. Conditions the three push-buttons (synchronize, debounce, rising-edge detect) and sequences loading of operand A, operand B and the operation code from the shared switch bus `entrada` into holding registers. These registers drive the ALU's `operando_A`, `operando_B` and `cod_operacion` inputs directly. A strict load order A → B → OP is enforced, and a valid flag is presented once all three are loaded.

## Interface
- `NBITS`, 8: width of the switch bus and of each operand.
- `COD_OP`, 6: operation-code width; taken from `entrada[COD_OP-1:0]`.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required before a debounced level changes; legal range is 2 or more.
- `clk`  in  1: system clock; all state is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `pulsador`  in  3: raw buttons, asynchronous. Bit 0 loads A, bit 1 loads B, bit 2 loads OP.
- `entrada`  in  NBITS: switch bus; quasi-static; sampled unsynchronized at the load edge.
- `operando_A`  out  NBITS: registered operand A.
- `operando_B`  out  NBITS: registered operand B.
- `cod_operacion`  out  COD_OP: registered operation code.
- `operandos_validos`  out  1: high while in `S_DONE`.
- `carga_completa`  out  1: one-cycle pulse on the cycle `S_DONE` is entered.
- `estado`  out  2: current FSM state, for LEDs/debug. `S_WAIT_A`=0, `S_WAIT_B`=1, `S_WAIT_OP`=2, `S_DONE`=3.

## Operation
- **Per-button path.** Each button passes through:
  - a 2-flop synchronizer (`sync1` → `sync2`);
  - a debouncer (see Configuration) producing level `db[i]`;
  - a registered previous level `db_q[i]`.
  - The resulting strobe is `ld[i] = db[i] & ~db_q[i]`, one cycle wide.
- **FSM**, reset state `S_WAIT_A`:
  - `S_WAIT_A`: `ld[0]` → `operando_A <= entrada`, go to `S_WAIT_B`.
  - `S_WAIT_B`: `ld[1]` → `operando_B <= entrada`, go to `S_WAIT_OP`.
  - `S_WAIT_OP`: `ld[2]` → `cod_operacion <= entrada[COD_OP-1:0]`, go to `S_DONE`, pulse `carga_completa`.
  - `S_DONE`: `ld[0]` → load A, go to `S_WAIT_B`. B and OP keep their old values until reloaded.
- **Out-of-order strobes** (any `ld` not expected in the current state) are dropped: no register change, no state change.
- **Simultaneous strobes:** only the expected one is accepted; the others are dropped and are not queued.
- **Held button:** produces exactly one strobe. A new strobe requires release (`db` low) followed by a new press.
- **No arithmetic.** `entrada` bits above `COD_OP` are ignored for the OP load.
- **Reset:**
  - All outputs are 0, state is `S_WAIT_A`.
  - All sync flops, `db`, `db_q` and debounce counters are 0.
  - Reset mid-sequence discards partially loaded operands.
  - A button held through reset release produces one strobe once its debounced level rises.

## Timing
- Let edge *k* be the first rising edge at which `pulsador[i]` is sampled high.
  - `sync2` is high after edge *k+1*.
  - With debounce: `db` goes high after edge *k+1+DEBOUNCE_CYCLES*, and the register loads at edge *k+2+DEBOUNCE_CYCLES*.
  - Without debounce: the register loads at edge *k+2*.
- Outputs change only on load edges or reset; there is no combinational path from input to output.
- `operandos_validos` rises on the same edge that loads `cod_operacion`. `carga_completa` is high for exactly that following cycle.
- Debounce counter rules:
  - It counts while `sync2 != db` and clears to 0 whenever `sync2 == db`.
  - `db` toggles, and the counter clears, on the edge where the counter equals `DEBOUNCE_CYCLES-1` and the mismatch persists.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles therefore never changes `db`.
- The counter width is `$clog2(DEBOUNCE_CYCLES)`; it never wraps.

## Configuration
- Macro: `OPERAND_LOADER_DEBOUNCE_EN`.
- **Defined:** debouncer per button as specified; `DEBOUNCE_CYCLES` is honoured.
- **Undefined:** no counters are instantiated and `db[i] = sync2[i]`. `DEBOUNCE_CYCLES` is ignored. This mode is for fast simulation and for boards with hardware-debounced buttons.

## Test plan
- **Reset state.** Assert `reset` mid-sequence (state `S_WAIT_OP`, A=0x12). Required: outputs immediately 0 and `estado`=0 (asynchronous), without waiting for a clock edge.
- **In-order load** (`DEBOUNCE_CYCLES`=4, macro defined).
  - Stimulus: `entrada`=0x3C with press 0, then 0xA5 with press 1, then 0x20 with press 2.
  - Required: A=0x3C, B=0xA5, OP=0x20; `carga_completa` pulses once; `operandos_validos`=1.
  - Each load lands exactly 6 edges after the press is first sampled.
- **Order enforcement.** From reset, press 1 and then press 2 with `entrada`=0x55. Required: B and OP stay 0, `estado` stays 0. A subsequent press 0 loads A=0x55.
- **Glitch rejection** (macro defined, `DEBOUNCE_CYCLES`=4).
  - Stimulus: 3-cycle pulse on `pulsador[0]`. Required: no load.
  - Stimulus: 4-cycle stable press. Required: one load.
  - Stimulus: press held for 100 cycles. Required: exactly one strobe.
- **Simultaneous and reload.**
  - From `S_WAIT_B`, assert `pulsador`=3'b111 with `entrada`=0x0F. Required: only B loads; state becomes `S_WAIT_OP`.
  - From `S_DONE`, press 0 with 0x77. Required: A=0x77, B/OP unchanged, `operandos_validos` drops to 0.
- **Macro undefined.** Press 0 sampled at edge *k*. Required: A updates at edge *k+2*; a 1-cycle pulse held through sync also loads.

Source files
------------

// File: rtl/operand_loader.sv
// ALU input stage: conditions three push-buttons and loads A, B and OP from the switch bus in strict order.
// Optional per-button debouncer enabled by defining OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader #(
   parameter int NBITS           = 8,
   parameter int COD_OP          = 6,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        pulsador,
   input  logic [NBITS-1:0]  entrada,
   output logic [NBITS-1:0]  operando_A,
   output logic [NBITS-1:0]  operando_B,
   output logic [COD_OP-1:0] cod_operacion,
   output logic              operandos_validos,
   output logic              carga_completa,
   output logic [1:0]        estado
);

   typedef enum logic [1:0] {
      S_WAIT_A  = 2'd0,
      S_WAIT_B  = 2'd1,
      S_WAIT_OP = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t     state, state_nx;
   logic [2:0] sync1, sync2, db, db_q, ld;
   logic       ld_a, ld_b, ld_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         db_q  <= '0;
      end else begin
         sync1 <= pulsador;
         sync2 <= sync1;
         db_q  <= db;
      end
   end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [2:0][CW-1:0] cnt;

   // db only flips after DEBOUNCE_CYCLES consecutive cycles of disagreement with sync2
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db  <= '0;
         cnt <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               db[i]  <= ~db[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end
`else
   assign db = sync2;
`endif

   assign ld = db & ~db_q;

   always_comb begin
      state_nx = state;
      ld_a     = 1'b0;
      ld_b     = 1'b0;
      ld_op    = 1'b0;
      case (state)
         S_WAIT_A, S_DONE: if (ld[0]) begin ld_a  = 1'b1; state_nx = S_WAIT_B;  end
         S_WAIT_B:         if (ld[1]) begin ld_b  = 1'b1; state_nx = S_WAIT_OP; end
         S_WAIT_OP:        if (ld[2]) begin ld_op = 1'b1; state_nx = S_DONE;    end
         default:          state_nx = S_WAIT_A;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_WAIT_A;
         operando_A     <= '0;
         operando_B     <= '0;
         cod_operacion  <= '0;
         carga_completa <= 1'b0;
      end else begin
         state          <= state_nx;
         carga_completa <= ld_op;
         if (ld_a)  operando_A    <= entrada;
         if (ld_b)  operando_B    <= entrada;
         if (ld_op) cod_operacion <= entrada[COD_OP-1:0];
      end
   end

   assign operandos_validos = (state == S_DONE);
   assign estado            = state;

endmodule

// File: tb/tb_operand_loader.sv
// Randomized self-checking bench for operand_loader against a sequence-level reference model.
module tb_operand_loader;

   localparam int DB = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
   localparam int LAT  = DB + 2;
   localparam int MINH = DB;
`else
   localparam int LAT  = 2;
   localparam int MINH = 1;
`endif
   localparam int SETTLE = DB + 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] pulsador;
   logic [7:0] entrada;
   logic [7:0] operando_A, operando_B;
   logic [5:0] cod_operacion;
   logic       operandos_validos, carga_completa;
   logic [1:0] estado;

   operand_loader #(.NBITS(8), .COD_OP(6), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .pulsador(pulsador), .entrada(entrada),
      .operando_A(operando_A), .operando_B(operando_B), .cod_operacion(cod_operacion),
      .operandos_validos(operandos_validos), .carga_completa(carga_completa), .estado(estado)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cc_count = 0;

   always @(posedge clk) begin
      #1;
      if (carga_completa === 1'b1) cc_count++;
   end

   // reference model: stage 0..3 = waiting A, B, OP, done
   logic [7:0] mA, mB;
   logic [5:0] mOP;
   int         mst;
   int         exp_cc = 0;

   task automatic model_press(input logic [2:0] m, input logic [7:0] v);
      case (mst)
         0, 3: if (m[0]) begin mA = v; mst = 1; end
         1:    if (m[1]) begin mB = v; mst = 2; end
         default: if (m[2]) begin mOP = v[5:0]; mst = 3; exp_cc++; end
      endcase
   endtask

   task automatic press(input logic [2:0] m, input logic [7:0] v, input int h);
      @(negedge clk);
      entrada  = v;
      pulsador = m;
      repeat (h) @(negedge clk);
      pulsador = 3'b000;
      repeat (SETTLE) @(negedge clk);
      if (h >= MINH) model_press(m, v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      pulsador = 3'b000;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mA = '0; mB = '0; mOP = '0; mst = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1; pulsador = 3'b000; entrada = 8'h00;
      #1;
      checks++;
      if ({operando_A, operando_B, cod_operacion, estado, operandos_validos, carga_completa} !== 25'd0) begin
         errors++;
         $display("FAIL reset_init: A=%h B=%h OP=%h st=%0d v=%b c=%b required all 0",
                  operando_A, operando_B, cod_operacion, estado, operandos_validos, carga_completa);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      mA = '0; mB = '0; mOP = '0; mst = 0;
   endtask

   task automatic test_in_order();
      logic [7:0] vals [3];
      logic [7:0] obs, exp_v;
      int         cc0;
      vals[0] = 8'h3C; vals[1] = 8'hA5; vals[2] = 8'h20;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         entrada  = vals[i];
         pulsador = 3'b001 << i;
         cc0      = cc_count;
         for (int j = 1; j <= LAT + 2; j++) begin
            @(negedge clk);
            case (i)
               0: obs = operando_A;
               1: obs = operando_B;
               default: obs = {2'b00, cod_operacion};
            endcase
            exp_v = (j >= LAT + 1) ? (vals[i] & ((i == 2) ? 8'h3F : 8'hFF)) : 8'h00;
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL latency reg%0d cycle%0d: got %h required %h", i, j, obs, exp_v);
            end
            if (i == 2) begin
               checks++;
               if (carga_completa !== (j == LAT + 1)) begin
                  errors++;
                  $display("FAIL carga_pulse cycle%0d: got %b required %b", j, carga_completa, j == LAT + 1);
               end
            end
         end
         pulsador = 3'b000;
         repeat (SETTLE) @(negedge clk);
         model_press(3'b001 << i, vals[i]);
         if (i == 2) begin
            checks++;
            if (cc_count - cc0 !== 1) begin
               errors++;
               $display("FAIL carga_count: got %0d required 1", cc_count - cc0);
            end
         end
      end
      checks++;
      if ({operando_A, operando_B, cod_operacion, estado, operandos_validos} !== {mA, mB, mOP, mst[1:0], mst == 3}) begin
         errors++;
         $display("FAIL in_order_state: A=%h B=%h OP=%h st=%0d v=%b required A=%h B=%h OP=%h st=%0d",
                  operando_A, operando_B, cod_operacion, estado, operandos_validos, mA, mB, mOP, mst);
      end
   endtask

   task automatic test_order();
      do_reset();
      press(3'b010, 8'h55, DB + 1);
      press(3'b100, 8'h55, DB + 1);
      checks++;
      if ({operando_B, cod_operacion, estado} !== 16'd0) begin
         errors++;
         $display("FAIL order_drop: B=%h OP=%h st=%0d required 0 0 0", operando_B, cod_operacion, estado);
      end
      press(3'b001, 8'h55, DB + 1);
      checks++;
      if ({operando_A, estado} !== {8'h55, 2'd1} || {operando_A, estado} !== {mA, mst[1:0]}) begin
         errors++;
         $display("FAIL order_load_a: A=%h st=%0d required 55 1", operando_A, estado);
      end
   endtask

   task automatic test_glitch();
      int hs [4];
      hs[0] = 1; hs[1] = 3; hs[2] = 4; hs[3] = 5;
      for (int i = 0; i < 4; i++) begin
         do_reset();
         press(3'b001, 8'h11 + 8'(i), hs[i]);
         checks++;
         if ({operando_A, estado} !== {mA, mst[1:0]}) begin
            errors++;
            $display("FAIL glitch_hold%0d: A=%h st=%0d required A=%h st=%0d", hs[i], operando_A, estado, mA, mst);
         end
      end
   endtask

   task automatic test_held();
      do_reset();
      @(negedge clk);
      entrada = 8'h31; pulsador = 3'b001;
      repeat (SETTLE) @(negedge clk);
      entrada = 8'h42; pulsador = 3'b011;
      repeat (DB + 2) @(negedge clk);
      pulsador = 3'b001;
      repeat (SETTLE) @(negedge clk);
      entrada = 8'h53; pulsador = 3'b101;
      repeat (DB + 2) @(negedge clk);
      pulsador = 3'b001;
      repeat (SETTLE) @(negedge clk);
      entrada = 8'h64;
      repeat (100) @(negedge clk);
      pulsador = 3'b000;
      repeat (SETTLE) @(negedge clk);
      mA = 8'h31; mB = 8'h42; mOP = 6'h13; mst = 3; exp_cc++;
      checks++;
      if ({operando_A, operando_B, cod_operacion, estado, operandos_validos} !== {8'h31, 8'h42, 6'h13, 2'd3, 1'b1}) begin
         errors++;
         $display("FAIL held_single: A=%h B=%h OP=%h st=%0d v=%b required 31 42 13 3 1",
                  operando_A, operando_B, cod_operacion, estado, operandos_validos);
      end
   endtask

   task automatic test_simul_reload();
      do_reset();
      press(3'b001, 8'hC3, DB + 1);
      press(3'b111, 8'h0F, DB + 1);
      checks++;
      if ({operando_A, operando_B, cod_operacion, estado} !== {8'hC3, 8'h0F, 6'h00, 2'd2}) begin
         errors++;
         $display("FAIL simultaneous: A=%h B=%h OP=%h st=%0d required c3 0f 00 2",
                  operando_A, operando_B, cod_operacion, estado);
      end
      press(3'b100, 8'hE9, DB + 1);
      press(3'b001, 8'h77, DB + 1);
      checks++;
      if ({operando_A, operando_B, cod_operacion, estado, operandos_validos} !== {8'h77, 8'h0F, 6'h29, 2'd1, 1'b0}) begin
         errors++;
         $display("FAIL reload_a: A=%h B=%h OP=%h st=%0d v=%b required 77 0f 29 1 0",
                  operando_A, operando_B, cod_operacion, estado, operandos_validos);
      end
   endtask

   task automatic test_random();
      logic [2:0] m;
      logic [7:0] v;
      int         h;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         m = 3'($urandom_range(1, 7));
         v = 8'($urandom);
         h = $urandom_range(1, 7);
         press(m, v, h);
         checks++;
         if ({operando_A, operando_B, cod_operacion, estado, operandos_validos} !== {mA, mB, mOP, mst[1:0], mst == 3}) begin
            errors++;
            $display("FAIL random%0d m=%b v=%h h=%0d: A=%h B=%h OP=%h st=%0d required A=%h B=%h OP=%h st=%0d",
                     n, m, v, h, operando_A, operando_B, cod_operacion, estado, mA, mB, mOP, mst);
         end
      end
      checks++;
      if (cc_count !== exp_cc) begin
         errors++;
         $display("FAIL carga_total: got %0d required %0d", cc_count, exp_cc);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      press(3'b001, 8'h12, DB + 1);
      press(3'b010, 8'h34, DB + 1);
      checks++;
      if ({operando_A, estado} !== {8'h12, 2'd2}) begin
         errors++;
         $display("FAIL pre_reset: A=%h st=%0d required 12 2", operando_A, estado);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({operando_A, operando_B, cod_operacion, estado, operandos_validos, carga_completa} !== 25'd0) begin
         errors++;
         $display("FAIL reset_async: A=%h B=%h OP=%h st=%0d required all 0",
                  operando_A, operando_B, cod_operacion, estado);
      end
      @(negedge clk);
      reset = 1'b0;
      mA = '0; mB = '0; mOP = '0; mst = 0;
      press(3'b100, 8'h3F, DB + 1);
      checks++;
      if ({operando_A, operando_B, cod_operacion, estado} !== 24'd0) begin
         errors++;
         $display("FAIL post_reset_order: A=%h B=%h OP=%h st=%0d required all 0",
                  operando_A, operando_B, cod_operacion, estado);
      end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_order();
      test_glitch();
      test_held();
      test_simul_reload();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
